// File: rtl/stn_pkg.sv
// Shared types for the STN pixel feeder: pixel depth, FSM state and per-word pixel count.
package stn_pkg;

  typedef enum logic [1:0] {BPP1, BPP2, BPP4, BPP8} bpp_e;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} feeder_state_e;

  function automatic logic [5:0] pix_per_word(bpp_e bpp);
    case (bpp)
      BPP1:    return 6'd32;
      BPP2:    return 6'd16;
      BPP4:    return 6'd8;
      default: return 6'd4;
    endcase
  endfunction

  // Encodings 4..7 of the bpp field fall back to 8bpp.
  function automatic bpp_e decode_bpp(logic [2:0] cfg);
    return cfg[2] ? BPP8 : bpp_e'(cfg[1:0]);
  endfunction

endpackage

// File: rtl/stn_pixel_expand.sv
// Widens a 1/2/4/8-bpp pixel to a full byte by repeating its bit pattern.
module stn_pixel_expand
  import stn_pkg::*;
(
  input  logic [7:0] i_raw,
  input  bpp_e       i_bpp,
  output logic [7:0] o_pix
);

  always_comb begin
    case (i_bpp)
      BPP1:    o_pix = {8{i_raw[0]}};
      BPP2:    o_pix = {4{i_raw[1:0]}};
      BPP4:    o_pix = {2{i_raw[3:0]}};
      default: o_pix = i_raw;
    endcase
  end

endmodule

// File: rtl/stn_pixel_feeder.sv
// Unpacks 32-bit DMA words into byte-wide pixels for the STN FIFO and tracks line ends.
// Build option STN_BEPO_EN adds cfg_bepo to select big-endian pixel order within a word.
module stn_pixel_feeder
  import stn_pkg::*;
#(
  parameter int PPL_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lcd_en,
  input  logic [2:0]       cfg_bpp,
  input  logic [PPL_W-1:0] cfg_ppl,
`ifdef STN_BEPO_EN
  input  logic             cfg_bepo,
`endif
  input  logic [31:0]      din,
  input  logic             din_empty,
  output logic             din_rd,
  output logic [7:0]       pixelstn,
  output logic             write,
  input  logic             full,
  output logic             line_done
);

  feeder_state_e    r_state;
  logic [31:0]      r_word;
  logic [4:0]       r_pix_idx;
  logic [PPL_W-1:0] r_ppl_cnt;
  logic             r_line_done;

  bpp_e       w_bpp;
  logic       w_run;
  logic       w_accept;
  logic       w_word_end;
  logic       w_line_end;
  logic       w_last;
  logic [5:0] w_offset;
  logic [5:0] w_shamt;
  logic [7:0] w_raw;
  logic [7:0] w_pix;

  assign w_bpp    = decode_bpp(cfg_bpp);
  // Reset and a dropped enable both suppress strobes in the same cycle they are seen.
  assign w_run    = lcd_en & ~reset;
  assign w_offset = {1'b0, r_pix_idx} << w_bpp;

`ifdef STN_BEPO_EN
  assign w_shamt = cfg_bepo ? (6'd32 - (6'd1 << w_bpp) - w_offset) : w_offset;
`else
  assign w_shamt = w_offset;
`endif

  assign w_raw = 8'(r_word >> w_shamt);

  stn_pixel_expand u_expand (
    .i_raw (w_raw),
    .i_bpp (w_bpp),
    .o_pix (w_pix)
  );

  assign write      = w_run & (r_state == SHIFT) & ~full;
  assign w_accept   = write;
  assign w_word_end = ({1'b0, r_pix_idx} == pix_per_word(w_bpp) - 6'd1);
  assign w_line_end = (r_ppl_cnt == cfg_ppl);
  // A line end drops the rest of the word, so it behaves like the word's last pixel.
  assign w_last     = w_word_end | w_line_end;

  assign din_rd = w_run & ~din_empty &
                  ((r_state == WAIT) | ((r_state == SHIFT) & w_accept & w_last));

  assign pixelstn  = (r_state == SHIFT) ? w_pix : 8'h00;
  assign line_done = r_line_done;

  always_ff @(posedge clk) begin
    if (reset || !lcd_en) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_pix_idx   <= '0;
      r_ppl_cnt   <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      case (r_state)
        IDLE: r_state <= WAIT;
        WAIT: begin
          if (din_rd) begin
            r_word    <= din;
            r_pix_idx <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_accept) begin
            r_ppl_cnt   <= w_line_end ? '0 : r_ppl_cnt + 1'b1;
            r_line_done <= w_line_end;
            if (w_last) begin
              r_pix_idx <= '0;
              if (din_rd) r_word  <= din;
              else        r_state <= WAIT;
            end else begin
              r_pix_idx <= r_pix_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stn_pixel_feeder.sv
// Directed bench for stn_pixel_feeder: upstream word queue, STN write log, hand-computed streams.
module tb_stn_pixel_feeder;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_en;
  logic [2:0]  cfg_bpp;
  logic [9:0]  cfg_ppl;
  logic [31:0] din;
  logic        din_empty;
  logic        din_rd;
  logic [7:0]  pixelstn;
  logic        write;
  logic        full;
  logic        line_done;
`ifdef STN_BEPO_EN
  logic        cfg_bepo = 1'b0;
`endif

  logic        rst_v, en_v, full_v;
  logic        obs_wr, obs_rd;
  logic [7:0]  obs_pix;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] up_q[$];
  logic [7:0]  wr_q[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  int          ld_cyc[$];

  always #5 clk = ~clk;

  stn_pixel_feeder #(.PPL_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .lcd_en    (lcd_en),
    .cfg_bpp   (cfg_bpp),
    .cfg_ppl   (cfg_ppl),
`ifdef STN_BEPO_EN
    .cfg_bepo  (cfg_bepo),
`endif
    .din       (din),
    .din_empty (din_empty),
    .din_rd    (din_rd),
    .pixelstn  (pixelstn),
    .write     (write),
    .full      (full),
    .line_done (line_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  // Drive all inputs after the falling edge, then log what the next rising edge will take.
  task automatic tick();
    @(negedge clk);
    reset     = rst_v;
    lcd_en    = en_v;
    full      = full_v;
    din_empty = (up_q.size() == 0);
    din       = din_empty ? 32'h0 : up_q[0];
    #1;
    obs_wr  = write;
    obs_rd  = din_rd;
    obs_pix = pixelstn;
    if (line_done) ld_cyc.push_back(cyc);
    if (write && !full) begin
      wr_q.push_back(pixelstn);
      wr_cyc.push_back(cyc);
      $display("cyc %0d: write pixel 0x%02h", cyc, pixelstn);
    end
    if (din_rd) begin
      rd_cyc.push_back(cyc);
      $display("cyc %0d: pop word 0x%08h", cyc, up_q[0]);
      void'(up_q.pop_front());
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart(input logic [2:0] bpp, input logic [9:0] ppl);
    en_v   = 1'b0;
    rst_v  = 1'b0;
    full_v = 1'b0;
    ticks(2);
    wr_q.delete(); wr_cyc.delete(); rd_cyc.delete(); ld_cyc.delete(); up_q.delete();
    cfg_bpp = bpp;
    cfg_ppl = ppl;
  endtask

  task automatic check_stream(input string tag, input byte_q_t e);
    chk({tag, "_count"}, wr_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), (i < wr_q.size()) ? wr_q[i] : 8'hxx, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t e;
    rst_v = 1'b1; en_v = 1'b1; full_v = 1'b0;
    reset = 1'b1; lcd_en = 1'b1; full = 1'b0;
    cfg_bpp = 3'd3; cfg_ppl = 10'd7; din = 32'h0; din_empty = 1'b1;
    up_q.push_back(32'hDEADBEEF);

    // Reset held with enable high and data available: everything stays quiet.
    ticks(3);
    chk("rst_din_rd", obs_rd, 1'b0);
    chk("rst_write", obs_wr, 1'b0);
    chk("rst_pixelstn", obs_pix, 8'h00);
    chk("rst_line_done", line_done, 1'b0);

    // 1: 8bpp, two words, 8-pixel line
    restart(3'd3, 10'd7);
    up_q.push_back(32'h44332211);
    up_q.push_back(32'h88776655);
    en_v = 1'b1;
    ticks(14);
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_stream("t1", e);
    chk("t1_consecutive", qi(wr_cyc, 7) - qi(wr_cyc, 0), 7);
    chk("t1_ld_count", ld_cyc.size(), 1);
    chk("t1_ld_cycle", qi(ld_cyc, 0), qi(wr_cyc, 7) + 1);
    chk("t1_rd_count", rd_cyc.size(), 2);
    chk("t1_rd_no_bubble", qi(rd_cyc, 1), qi(wr_cyc, 3));

    // 2: 1bpp, one word, 32-pixel line
    restart(3'd0, 10'd31);
    up_q.push_back(32'h0000_0005);
    en_v = 1'b1;
    ticks(40);
    e = {};
    for (int i = 0; i < 32; i++) e.push_back((i == 0 || i == 2) ? 8'hFF : 8'h00);
    check_stream("t2", e);
    chk("t2_ld_count", ld_cyc.size(), 1);
    chk("t2_ld_cycle", qi(ld_cyc, 0), qi(wr_cyc, 31) + 1);

    // 3: 4bpp with back-pressure after the first write
    restart(3'd2, 10'd7);
    up_q.push_back(32'h0000_00A3);
    en_v = 1'b1;
    for (int k = 0; k < 10 && wr_q.size() < 1; k++) tick();
    chk("t3_first_write", wr_q.size(), 1);
    full_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_hold_pix%0d", k), obs_pix, 8'hAA);
      chk($sformatf("t3_hold_rd%0d", k), obs_rd, 1'b0);
    end
    chk("t3_no_write_while_full", wr_q.size(), 1);
    full_v = 1'b0;
    ticks(12);
    e = '{8'h33, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_stream("t3", e);
    chk("t3_rd_count", rd_cyc.size(), 1);

    // 4: 2bpp, 6-pixel lines truncate words; next word follows with no bubble
    restart(3'd1, 10'd5);
    up_q.push_back(32'hFFFF_FFE4);
    up_q.push_back(32'h0000_001B);
    en_v = 1'b1;
    ticks(18);
    e = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00};
    check_stream("t4", e);
    chk("t4_rd_count", rd_cyc.size(), 2);
    chk("t4_rd_at_line_end", qi(rd_cyc, 1), qi(wr_cyc, 5));
    chk("t4_no_bubble", qi(wr_cyc, 6), qi(wr_cyc, 5) + 1);
    chk("t4_ld_count", ld_cyc.size(), 2);
    chk("t4_ld_first", qi(ld_cyc, 0), qi(wr_cyc, 5) + 1);

    // 5: abort mid-word by enable (mode 0) or reset (mode 1); bpp=6 decodes as 8bpp
    for (int mode = 0; mode < 2; mode++) begin
      restart(3'd6, 10'd7);
      up_q.push_back(32'h44332211);
      up_q.push_back(32'h88776655);
      en_v = 1'b1;
      ticks(4);
      chk($sformatf("t5m%0d_pre", mode), wr_q.size(), 2);
      if (mode == 0) en_v = 1'b0;
      else           rst_v = 1'b1;
      tick();
      chk($sformatf("t5m%0d_stop_wr", mode), obs_wr, 1'b0);
      tick();
      chk($sformatf("t5m%0d_idle_wr", mode), obs_wr, 1'b0);
      en_v = 1'b1;
      rst_v = 1'b0;
      ticks(10);
      e = '{8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
      check_stream($sformatf("t5m%0d", mode), e);
      chk($sformatf("t5m%0d_rd_count", mode), rd_cyc.size(), 2);
      chk($sformatf("t5m%0d_ld_count", mode), ld_cyc.size(), 0);
    end

`ifdef STN_BEPO_EN
    // 6: big-endian pixel order
    restart(3'd3, 10'd3);
    cfg_bepo = 1'b1;
    up_q.push_back(32'h44332211);
    en_v = 1'b1;
    ticks(10);
    e = '{8'h44, 8'h33, 8'h22, 8'h11};
    check_stream("t6", e);
    chk("t6_ld_count", ld_cyc.size(), 1);
    cfg_bepo = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
